// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int MAX_DEC    = 9999;
  localparam int N_ITER     = 16;
  localparam int BCD_DIGITS = 4;
  localparam int CNT_W      = 5;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a requester and bin_to_bcd_seq.
interface bin_to_bcd_seq_if;
  import bin_to_bcd_seq_pkg::*;

  logic                      START;
  logic [15:0]               BIN;
  logic [4*BCD_DIGITS-1:0]   BCD;
  logic                      OVF;
  logic                      BUSY;
  logic                      DONE;

  modport master (output START, BIN, input BCD, OVF, BUSY, DONE);
  modport slave  (input START, BIN, output BCD, OVF, BUSY, DONE);

endinterface

// File: rtl/bin_to_bcd_seq_bcd_digit_adj.sv
// Double-dabble digit corrector: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Digits entering correction never exceed 9, so the 4-bit sum cannot wrap.
  assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential 16-bit binary to 4-digit packed BCD converter (shift-and-add-3),
// fixed 18-cycle conversion with saturating overflow code.
//
// state  | meaning
// IDLE   | waiting for START, outputs hold last result
// SHIFT  | 16 correct-and-shift iterations
// FINISH | publish result, pulse DONE
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter logic [15:0] OVF_CODE = 16'h9999
) (
  input  logic               CLK,
  input  logic               RST,
  bin_to_bcd_seq_if.slave    bus
);

  state_t            state, state_nxt;
  logic [15:0]       shift_q;
  logic [15:0]       scratch_q;
  logic [15:0]       scratch_adj;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_flag_q;
  logic [15:0]       bcd_q;
  logic              ovf_q;
  logic              busy_q;
  logic              done_q;
  logic              accept;
  logic              publish;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (scratch_q[4*g +: 4]),
      .digit_out (scratch_adj[4*g +: 4])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    publish   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.START) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(N_ITER - 1)) state_nxt = FINISH;
      end
      FINISH: begin
        publish   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      busy_q <= (state_nxt == SHIFT);
      done_q <= publish;
      if (accept) begin
        shift_q    <= bus.BIN;
        scratch_q  <= '0;
        cnt_q      <= '0;
        ovf_flag_q <= (bus.BIN > 16'(MAX_DEC));
      end
      if (state == SHIFT) begin
        {scratch_q, shift_q} <= {scratch_adj[14:0], shift_q, 1'b0};
        cnt_q                <= cnt_q + CNT_W'(1);
      end
      // Overflowed inputs still run all 16 iterations so latency is constant.
      if (publish) begin
        bcd_q <= ovf_flag_q ? OVF_CODE : scratch_q;
        ovf_q <= ovf_flag_q;
      end
    end
  end

  assign bus.BCD  = bcd_q;
  assign bus.OVF  = ovf_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter OVF_CODE, default 16'h9999: packed-BCD value driven on BCD when the input exceeds 9999.
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 START  input  1  conversion request; sampled only in IDLE.
REQ-005 BIN  input  16  unsigned binary value; sampled on the cycle START is accepted.
REQ-006 BCD  output  16  packed 4-digit BCD result, digit 0 in [3:0]; feeds the 4-digit display driver NUM input directly.
REQ-007 OVF  output  1  BIN exceeded 9999 on the last completed conversion.
REQ-008 BUSY  output  1  high while a conversion is in progress (SHIFT state).
REQ-009 DONE  output  1  single-cycle pulse marking BCD/OVF update.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT and FINISH, with IDLE after reset.
REQ-011 In IDLE with START=1, the block SHALL latch BIN into a 16-bit shift register, clear the 16-bit BCD scratch and a 5-bit iteration counter, set an internal overflow flag to (BIN > 9999), and enter SHIFT.
REQ-012 In SHIFT, each cycle SHALL first add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one bit, then increment the counter.
REQ-013 After the 16th SHIFT cycle (counter = 15 at the edge), the FSM SHALL enter FINISH.
REQ-014 In FINISH, BCD SHALL load the scratch value, or OVF_CODE if the overflow flag is set; OVF SHALL load the flag; DONE SHALL be 1 for exactly that cycle; the next state SHALL be IDLE.
REQ-015 Latency SHALL be fixed: START accepted at edge N gives DONE=1 and the new BCD in the cycle after edge N+17, for all BIN values including overflow.
REQ-016 Throughput SHALL be one conversion per 18 cycles; START in SHIFT or FINISH SHALL be ignored and not queued.
REQ-017 BUSY SHALL equal (state == SHIFT), registered.
REQ-018 BCD and OVF SHALL hold their last values between FINISH events, giving the display a glitch-free, stable source.
REQ-019 BIN changes after acceptance SHALL NOT affect the conversion in flight.
REQ-020 Boundary values:
  - BIN = 9999 SHALL give 16'h9999 with OVF=0.
  - BIN = 10000 SHALL give OVF_CODE with OVF=1.
  - BIN = 65535 SHALL give OVF_CODE with OVF=1.
  - BIN = 0 SHALL give 16'h0000 with OVF=0.
REQ-021 Each scratch digit SHALL be 4 bits with no carry between digits during correction; overflow is decided solely by the range check in REQ-011.

Reset
REQ-022 RST=1 SHALL force, at the next edge:
  - state = IDLE
  - BCD = 16'h0000
  - OVF = 0, BUSY = 0, DONE = 0
  - counter, scratch and shift register cleared
REQ-023 RST SHALL take priority over START and over any in-flight conversion; an aborted conversion SHALL produce no DONE pulse.
REQ-024 The first START after RST deasserts SHALL be accepted normally.

Structure
REQ-025 The shared package SHALL hold:
  - the state enumeration (IDLE, SHIFT, FINISH)
  - constant MAX_DEC = 9999
  - constant N_ITER = 16
  - constant BCD_DIGITS = 4
REQ-026 The per-digit "add 3 if >= 5" corrector SHALL be a combinational sub-module, bcd_digit_adj, instantiated 4 times.
REQ-027 The block SHALL contain no other sub-modules; its outputs SHALL be registers.

Verification
REQ-028 RST high for 2 cycles, then release -> BCD=0000, OVF=0, BUSY=0, DONE=0; START with BIN=1234 -> BUSY high 16 cycles, DONE pulse 17 cycles after acceptance, BCD=16'h1234, OVF=0.
REQ-029 Back-to-back BIN=0, then 9999 (START re-raised on the first IDLE cycle) -> BCD=16'h0000, then 16'h9999, OVF=0 both times, 18-cycle spacing between DONE pulses.
REQ-030 BIN=10000, then BIN=65535 -> BCD=16'h9999 (default OVF_CODE), OVF=1, same latency; then BIN=42 -> BCD=16'h0042, OVF=0.
REQ-031 START held high throughout, and BIN changed to 7777 mid-conversion of 2025 -> BCD=16'h2025; the next accepted value is 7777 -> 16'h7777.
REQ-032 RST pulsed at SHIFT cycle 8 of BIN=5555 -> no DONE; BCD=0000, BUSY=0 on the next cycle; a following START with 5555 -> 16'h5555.
REQ-033 Random BIN sweep with a scoreboard: BCD equals the decimal digits of BIN for BIN <= 9999, else OVF_CODE with OVF=1.
